// File: rtl/mmio_responder.sv
// Single-port MMIO responder: 256-word RAM, LED register, synchronized switches and cycle counter.
// Each access takes three cycles: capture (IDLE), decode/execute (ACCESS), respond (RESP).
module mmio_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [3:0]  io_in,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [7:0]  led_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  funct3_q;
    logic [3:0]  sync1_q, sync2_q;
    logic [31:0] cycle_q;
    logic [7:0]  led_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [256];

    logic        sel_ram, sel_led, sel_io, sel_cnt, mapped;
    logic        f3_ok, align_ok, acc_err;
    logic [31:0] rd_word, shifted, load_val, wdata_al;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  be;
    logic        do_store, ram_we, led_we;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (req) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == StIdle && req) begin
            we_q     <= we;
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            cycle_q <= 32'd0;
        end else begin
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign sel_ram = (addr_q[31:10] == 22'd0);
    assign sel_led = (addr_q == 32'h0000_1000);
    assign sel_io  = (addr_q == 32'h0000_1004);
    assign sel_cnt = (addr_q == 32'h0000_1008);
    assign mapped  = sel_ram | sel_led | sel_io | sel_cnt;

    // Width legality and alignment; unsigned widths exist only for loads.
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        case (funct3_q)
            3'b000: f3_ok = 1'b1;
            3'b001: begin
                f3_ok    = 1'b1;
                align_ok = ~addr_q[0];
            end
            3'b010: begin
                f3_ok    = 1'b1;
                align_ok = (addr_q[1:0] == 2'b00);
            end
            3'b100: f3_ok = ~we_q;
            3'b101: begin
                f3_ok    = ~we_q;
                align_ok = ~addr_q[0];
            end
            default: f3_ok = 1'b0;
        endcase
        acc_err = ~mapped | ~f3_ok | ~align_ok;
    end

    always_comb begin
        rd_word = 32'd0;
        if (sel_ram)      rd_word = mem[addr_q[9:2]];
        else if (sel_led) rd_word = {24'd0, led_q};
        else if (sel_io)  rd_word = {28'd0, sync2_q};
        else if (sel_cnt) rd_word = cycle_q;
    end

    assign shifted = rd_word >> {addr_q[1:0], 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = 32'd0;
        case (funct3_q)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_val = {24'd0, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b101:  load_val = {16'd0, half_v};
            3'b010:  load_val = rd_word;
            default: load_val = 32'd0;
        endcase
    end

    // Replicate store data across lanes so the byte enables alone pick the target.
    always_comb begin
        be       = 4'b0000;
        wdata_al = wdata_q;
        case (funct3_q)
            3'b000: begin
                be       = 4'b0001 << addr_q[1:0];
                wdata_al = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata_q[15:0]}};
            end
            3'b010: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign do_store = (state_q == StAccess) && we_q && !acc_err && !reset;
    assign ram_we   = do_store && sel_ram;
    assign led_we   = do_store && sel_led;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[9:2]][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       led_q <= 8'd0;
        else if (led_we) led_q <= wdata_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (state_q == StAccess) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || we_q) ? 32'd0 : load_val;
        end
    end

    assign ready   = (state_q == StResp);
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: one task per feature, inline comparisons, one summary line.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [3:0]  io_in = 4'd0;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  led_out;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_responder dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .funct3  (funct3),
        .io_in   (io_in),
        .ready   (ready),
        .rdata   (rdata),
        .err     (err),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    // Issues one request from IDLE; lat = edges from the sampling edge to ready (0 = no response).
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, output logic [31:0] rd, output logic e,
                       output int lat);
        lat = 0;
        rd  = 32'd0;
        e   = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ready) begin
                lat = i; rd = rdata; e = err;
                break;
            end
        end
        req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic e; int lat;
        @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_tests++; if (led_out !== 8'd0) begin n_fail++; $display("FAIL reset_led got %h want 0", led_out); end
        apply_reset();
        // Counter is 0 at the last reset edge; the load's ACCESS cycle sits two edges later.
        bus(1'b0, 32'h1008, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'd2) begin n_fail++; $display("FAIL reset_counter got %h want 2", rd); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat;
        bus(1'b1, 32'h010, 32'hDEAD_BEEF, 3'b010, rd, e, lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
        n_tests++; if (e !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", e, rd); end
        bus(1'b0, 32'h010, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
        n_tests++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin n_fail++; $display("FAIL lw_data got %h err=%b want deadbeef err=0", rd, e); end
        @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_one_cycle got %b want 0", ready); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic e; int lat;
        bus(1'b1, 32'h013, 32'h0000_0080, 3'b000, rd, e, lat);
        bus(1'b0, 32'h013, 32'd0, 3'b000, rd, e, lat);
        n_tests++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb got %h want ffffff80", rd); end
        bus(1'b0, 32'h013, 32'd0, 3'b100, rd, e, lat);
        n_tests++; if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu got %h want 00000080", rd); end
        bus(1'b0, 32'h010, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'h80AD_BEEF) begin n_fail++; $display("FAIL lw_after_sb got %h want 80adbeef", rd); end
        bus(1'b0, 32'h012, 32'd0, 3'b001, rd, e, lat);
        n_tests++; if (rd !== 32'hFFFF_80AD) begin n_fail++; $display("FAIL lh_hi got %h want ffff80ad", rd); end
        bus(1'b0, 32'h010, 32'd0, 3'b101, rd, e, lat);
        n_tests++; if (rd !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_lo got %h want 0000beef", rd); end
        bus(1'b1, 32'h010, 32'h0000_1234, 3'b001, rd, e, lat);
        bus(1'b0, 32'h010, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'h80AD_1234) begin n_fail++; $display("FAIL sh_lo got %h want 80ad1234", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        bus(1'b0, 32'h011, 32'd0, 3'b001, rd, e, lat);
        n_tests++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lh_misaligned got err=%b rdata=%h want 1/0", e, rd); end
        bus(1'b1, 32'h000, 32'h1234_5678, 3'b010, rd, e, lat);
        bus(1'b1, 32'h2000, 32'h0000_0001, 3'b010, rd, e, lat);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL sw_unmapped got err=%b want 1", e); end
        bus(1'b0, 32'h000, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_unchanged got %h want 12345678", rd); end
        bus(1'b0, 32'h010, 32'd0, 3'b011, rd, e, lat);
        n_tests++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load_f3_011 got err=%b rdata=%h want 1/0", e, rd); end
        bus(1'b1, 32'h010, 32'hFFFF_FFFF, 3'b100, rd, e, lat);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL store_f3_100 got err=%b want 1", e); end
        bus(1'b0, 32'h012, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL lw_misaligned got err=%b want 1", e); end
        bus(1'b0, 32'h010, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'h80AD_1234 || e !== 1'b0) begin n_fail++; $display("FAIL no_write_on_err got %h err=%b want 80ad1234/0", rd, e); end
    endtask

    task automatic test_led_io();
        logic [31:0] rd; logic e; int lat;
        bus(1'b1, 32'h1000, 32'h0000_01A5, 3'b010, rd, e, lat);
        n_tests++; if (led_out !== 8'hA5) begin n_fail++; $display("FAIL led_write got %h want a5", led_out); end
        bus(1'b0, 32'h1000, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_read got %h want 000000a5", rd); end
        bus(1'b0, 32'h1000, 32'd0, 3'b000, rd, e, lat);
        n_tests++; if (rd !== 32'hFFFF_FFA5) begin n_fail++; $display("FAIL led_lb got %h want ffffffa5", rd); end
        bus(1'b1, 32'h1004, 32'h0000_00FF, 3'b010, rd, e, lat);
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL ro_store_err got %b want 0", e); end
        io_in = 4'b1010;
        repeat (3) @(negedge clk);
        bus(1'b0, 32'h1004, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'h0000_000A) begin n_fail++; $display("FAIL io_read got %h want 0000000a", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v1, v2;
        int gap;
        bit seen;
        v1 = 32'd0; v2 = 32'd0; gap = 0; seen = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h1008; funct3 = 3'b010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) begin v1 = rdata; seen = 1'b1; break; end
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ready) begin v2 = rdata; gap = i; break; end
        end
        req = 1'b0;
        n_tests++; if (!seen || gap !== 3) begin n_fail++; $display("FAIL b2b_gap got %0d want 3", gap); end
        n_tests++; if (v2 - v1 !== 32'd3) begin n_fail++; $display("FAIL b2b_counter got %h want %h", v2, v1 + 32'd3); end
    endtask

    task automatic test_counter_wrap();
        @(posedge clk);
        #1 force dut.cycle_q = 32'hFFFF_FFFF;
        #1 release dut.cycle_q;
        @(posedge clk);
        #1;
        n_tests++; if (dut.cycle_q !== 32'd0) begin n_fail++; $display("FAIL counter_wrap got %h want 0", dut.cycle_q); end
        @(posedge clk);
        #1;
        n_tests++; if (dut.cycle_q !== 32'd1) begin n_fail++; $display("FAIL counter_after_wrap got %h want 1", dut.cycle_q); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int lat;
        int pulses;
        pulses = 0;
        bus(1'b1, 32'h020, 32'h0000_0000, 3'b010, rd, e, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h020; wdata = 32'h0000_0055; funct3 = 3'b010;
        @(negedge clk);
        reset = 1'b1; req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        reset = 1'b0;
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_ready got %0d pulses want 0", pulses); end
        n_tests++; if (led_out !== 8'd0) begin n_fail++; $display("FAIL abort_led got %h want 0", led_out); end
        bus(1'b0, 32'h020, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL abort_no_store got %h want 0", rd); end
        bus(1'b1, 32'h020, 32'h0000_0055, 3'b010, rd, e, lat);
        bus(1'b0, 32'h020, 32'd0, 3'b010, rd, e, lat);
        n_tests++; if (rd !== 32'h0000_0055) begin n_fail++; $display("FAIL reissue_store got %h want 00000055", rd); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_led_io();
        test_back_to_back();
        test_counter_wrap();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

endmodule
